// File: rtl/seg_scan_decoder_pkg.sv
// seg_scan_decoder_pkg: shared 7-segment display constants, glyph table and sample classification
package seg_scan_decoder_pkg;
    localparam int NUM_DIGITS = 5;
    localparam logic [4:0] CODE_BLANK = 5'd16;
    localparam int SEG_A = 0;
    localparam int SEG_G = 6;
    localparam int SEG_DP = 7;
    // Active-high gfedcba patterns for hex codes 0..F
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    typedef enum logic [1:0] {
        SMP_IDLE,
        SMP_ONEHOT,
        SMP_MULTI
    } sample_kind_e;
endpackage

// File: rtl/seg_scan_decoder_glyph_decode.sv
// seg7_glyph_decode: maps an active-high 7-segment pattern to a hex/blank code
module seg7_glyph_decode
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic [4:0] o_code,
    output logic       o_valid
);
    // All segments off is blank; otherwise search the glyph table
    always_comb begin
        o_code = CODE_BLANK;
        o_valid = (i_pattern == 7'd0);
        for (int k = 0; k < 16; k++) begin
            if (i_pattern == GLYPH_TABLE[k]) begin
                o_code = 5'(k);
                o_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers digit codes from a scanned multiplexed 7-segment display bus
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int SEL_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int STABLE_SAMPLES = 2,
    parameter int TIMEOUT_SAMPLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sample_en,
    input  logic [4:0]  seg_sel,
    input  logic [7:0]  seg_data,
    output logic [24:0] digits,
    output logic [4:0]  dps,
    output logic        frame_valid,
    output logic        pattern_err,
    output logic        sel_err,
    output logic [7:0]  err_count,
    output logic        stale
);
    localparam logic [3:0] STB = 4'(STABLE_SAMPLES);
    localparam logic [15:0] TMO = 16'(TIMEOUT_SAMPLES);

    logic [4:0] w_sel;
    logic [7:0] w_data;
    sample_kind_e w_kind;
    logic w_same;
    logic [3:0] w_cnt_nxt;
    logic w_accept;
    logic w_wr;
    logic w_err;
    logic w_full;
    logic [4:0] w_code;
    logic w_gvalid;

    logic [4:0] r_sel;
    logic [7:0] r_data;
    logic [3:0] r_cnt;
    logic [4:0] r_work [NUM_DIGITS];
    logic [4:0] r_work_dp;
    logic [4:0] r_seen;
    logic [24:0] r_digits;
    logic [4:0] r_dps;
    logic r_fv;
    logic r_perr;
    logic r_serr;
    logic [7:0] r_err;
    logic [15:0] r_tcnt;

    assign w_sel = (SEL_ACTIVE_LOW != 0) ? ~seg_sel : seg_sel;
    assign w_data = (SEG_ACTIVE_LOW != 0) ? ~seg_data : seg_data;

    seg7_glyph_decode u_glyph (
        .i_pattern(w_data[SEG_G:SEG_A]),
        .o_code   (w_code),
        .o_valid  (w_gvalid)
    );

    // Classify the sample and decide whether this strobe completes a stable run
    always_comb begin
        w_kind = (w_sel == 5'd0) ? SMP_IDLE
               : ((w_sel & (w_sel - 5'd1)) == 5'd0) ? SMP_ONEHOT : SMP_MULTI;
        w_same = (w_sel == r_sel) && (w_data == r_data);
        w_cnt_nxt = !w_same ? 4'd1 : (r_cnt == STB) ? r_cnt : r_cnt + 4'd1;
        w_accept = sample_en && (w_kind == SMP_ONEHOT) && (w_cnt_nxt == STB)
                && !(w_same && (r_cnt == STB));
        w_wr = w_accept && w_gvalid;
        w_err = (sample_en && (w_kind == SMP_MULTI)) || (w_accept && !w_gvalid);
        w_full = &r_seen;
    end

    // Track the held one-hot pair and its run length; idle or multi-hot breaks the run
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel <= '0;
            r_data <= '0;
            r_cnt <= '0;
        end else if (sample_en) begin
            if (w_kind == SMP_ONEHOT) begin
                r_sel <= w_sel;
                r_data <= w_data;
                r_cnt <= w_cnt_nxt;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Collect digits into working registers and publish a snapshot once all five are seen
    always_ff @(posedge clk) begin
        if (reset) begin
            r_seen <= '0;
            r_work_dp <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) r_work[i] <= CODE_BLANK;
            r_digits <= {NUM_DIGITS{CODE_BLANK}};
            r_dps <= '0;
            r_fv <= 1'b0;
        end else begin
            r_fv <= w_full;
            r_seen <= (w_full ? 5'd0 : r_seen) | (w_wr ? w_sel : 5'd0);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_wr && w_sel[i]) begin
                    r_work[i] <= w_code;
                    r_work_dp[i] <= w_data[SEG_DP];
                end
                if (w_full) r_digits[5*i +: 5] <= r_work[i];
            end
            if (w_full) r_dps <= r_work_dp;
        end
    end

    // Error pulses, saturating error count and frame timeout counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_serr <= 1'b0;
            r_perr <= 1'b0;
            r_err <= '0;
            r_tcnt <= '0;
        end else begin
            r_serr <= sample_en && (w_kind == SMP_MULTI);
            r_perr <= w_accept && !w_gvalid;
            if (w_err && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
            if (w_full) r_tcnt <= '0;
            else if (sample_en && (r_tcnt != TMO)) r_tcnt <= r_tcnt + 16'd1;
        end
    end

    assign digits = r_digits;
    assign dps = r_dps;
    assign frame_valid = r_fv;
    assign pattern_err = r_perr;
    assign sel_err = r_serr;
    assign err_count = r_err;
    assign stale = (r_tcnt == TMO);
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: randomized scoreboard bench with a behavioural display-scan model
module tb_seg_scan_decoder;
    localparam int STB = 2;
    localparam int TMO = 64;
    localparam logic [6:0] GL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [24:0] BLANKS = {5{5'd16}};
    localparam logic [24:0] EXP_FRAME = {5'd3, 5'd0, 5'd16, 5'd3, 5'd0};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sample_en = 1'b0;
    logic [4:0] seg_sel = 5'h1F;
    logic [7:0] seg_data = 8'hFF;
    logic [24:0] digits;
    logic [4:0] dps;
    logic frame_valid, pattern_err, sel_err, stale;
    logic [7:0] err_count;

    int n_tests = 0;
    int n_fail = 0;

    int m_run, m_tcnt, m_ecnt;
    int m_code [5];
    logic [4:0] m_hsel, m_dp, m_seen;
    logic [7:0] m_hdat;
    bit m_pend, m_after_rst, started;

    logic [24:0] q_dig [$];
    logic [4:0] q_dp [$];
    int q_err [$];

    seg_scan_decoder #(
        .SEL_ACTIVE_LOW(1),
        .SEG_ACTIVE_LOW(1),
        .STABLE_SAMPLES(STB),
        .TIMEOUT_SAMPLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .sample_en(sample_en),
        .seg_sel(seg_sel),
        .seg_data(seg_data),
        .digits(digits),
        .dps(dps),
        .frame_valid(frame_valid),
        .pattern_err(pattern_err),
        .sel_err(sel_err),
        .err_count(err_count),
        .stale(stale)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    function automatic int decode(input logic [6:0] p);
        if (p == 7'd0) return 16;
        for (int k = 0; k < 16; k++) if (GL[k] == p) return k;
        return -1;
    endfunction

    task automatic model(input logic r, input logic en, input logic [4:0] sel_raw, input logic [7:0] dat_raw);
        logic [4:0] s;
        logic [7:0] d;
        logic [24:0] snap;
        int c;
        s = ~sel_raw;
        d = ~dat_raw;
        m_after_rst = r;
        if (r) begin
            m_run = 0; m_tcnt = 0; m_ecnt = 0;
            m_hsel = '0; m_hdat = '0; m_dp = '0; m_seen = '0; m_pend = 0;
            for (int i = 0; i < 5; i++) m_code[i] = 16;
            return;
        end
        if (m_pend) begin
            for (int i = 0; i < 5; i++) snap[5*i +: 5] = 5'(m_code[i]);
            q_dig.push_back(snap);
            q_dp.push_back(m_dp);
            m_seen = '0;
            m_tcnt = 0;
            m_pend = 0;
        end else if (en && m_tcnt < TMO) begin
            m_tcnt++;
        end
        if (en) begin
            if (s == 5'd0) begin
                m_run = 0;
            end else if ($countones(s) > 1) begin
                m_run = 0;
                q_err.push_back(1);
                if (m_ecnt < 255) m_ecnt++;
            end else begin
                m_run = (s == m_hsel && d == m_hdat) ? m_run + 1 : 1;
                m_hsel = s;
                m_hdat = d;
                if (m_run == STB) begin
                    c = decode(d[6:0]);
                    if (c < 0) begin
                        q_err.push_back(2);
                        if (m_ecnt < 255) m_ecnt++;
                    end else begin
                        for (int i = 0; i < 5; i++) begin
                            if (s[i]) begin
                                m_code[i] = c;
                                m_dp[i] = d[7];
                                m_seen[i] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
        m_pend = (m_seen == 5'h1F);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_prev();
        if (!started) return;
        check("err_count", 32'(err_count), 32'(m_ecnt));
        check("stale", 32'(stale), 32'(m_tcnt == TMO));
        if (m_after_rst) begin
            check("reset_digits", 32'(digits), 32'(BLANKS));
            check("reset_dps", 32'(dps), 32'd0);
            check("reset_frame_valid", 32'(frame_valid), 32'd0);
            check("reset_err_pulses", 32'({pattern_err, sel_err}), 32'd0);
        end
    endtask

    task automatic drive(input logic r, input logic en, input logic [4:0] sel, input logic [7:0] dat);
        @(posedge clk);
        #1;
        check_prev();
        started = 1;
        reset = r;
        sample_en = en;
        seg_sel = sel;
        seg_data = dat;
        model(r, en, sel, dat);
    endtask

    task automatic show(input int d, input logic [7:0] dat, input int n);
        logic [4:0] s;
        s = ~(5'd1 << d);
        for (int k = 0; k < n; k++) drive(0, 1, s, dat);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 5'h1F, 8'hFF);
    endtask

    // Monitor: pop expected frames and error pulses whenever the DUT presents them
    always @(negedge clk) begin
        logic [24:0] ed;
        logic [4:0] ep;
        int ee;
        if (frame_valid === 1'b1) begin
            if (q_dig.size() == 0) begin
                check("frame_unexpected", 32'd1, 32'd0);
            end else begin
                ed = q_dig.pop_front();
                ep = q_dp.pop_front();
                check("frame_digits", 32'(digits), 32'(ed));
                check("frame_dps", 32'(dps), 32'(ep));
            end
        end
        if (sel_err === 1'b1 || pattern_err === 1'b1) begin
            if (q_err.size() == 0) begin
                check("err_unexpected", 32'({pattern_err, sel_err}), 32'd0);
            end else begin
                ee = q_err.pop_front();
                check("err_kind", 32'({pattern_err, sel_err}), 32'(ee));
            end
        end
    end

    initial begin
        logic [4:0] s;
        logic [7:0] dat;
        int r, reps, d;
        drive(1, 0, 5'h1F, 8'hFF);
        idle(2);
        show(0, 8'hC0, 2);
        show(1, 8'hB0, 2);
        show(2, 8'hFF, 2);
        show(3, 8'hC0, 2);
        show(4, 8'hB0, 2);
        idle(2);
        check("frame_fields", 32'(digits), 32'(EXP_FRAME));
        check("frame_dps_zero", 32'(dps), 32'd0);
        drive(1, 0, 5'h1F, 8'hFF);
        drive(0, 1, 5'b11100, 8'hC0);
        idle(1);
        check("sel_err_count", 32'(err_count), 32'd1);
        show(2, 8'hAA, 2);
        idle(2);
        check("pattern_err_count", 32'(err_count), 32'd2);
        drive(1, 0, 5'h1F, 8'hFF);
        show(0, 8'hC0, 1);
        show(0, 8'hB0, 1);
        for (int k = 0; k < 64; k++) drive(0, 1, 5'h1F, 8'hFF);
        idle(1);
        check("stale_set", 32'(stale), 32'd1);
        for (int i = 0; i < 5; i++) show(i, 8'hF9, 2);
        idle(2);
        check("stale_cleared", 32'(stale), 32'd0);
        show(0, 8'hC0, 2);
        show(1, 8'hC0, 2);
        show(2, 8'hC0, 2);
        drive(1, 0, 5'h1F, 8'hFF);
        show(3, 8'h92, 2);
        show(4, 8'h92, 2);
        idle(3);
        for (int i = 0; i < 5; i++) show(i, 8'h99, 2);
        idle(2);
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            d = $urandom_range(0, 4);
            if (r < 8) begin
                s = ~((5'd1 << d) | (5'd1 << ((d + 1 + $urandom_range(0, 3)) % 5)));
            end else if (r < 14) begin
                s = 5'h1F;
            end else begin
                s = ~(5'd1 << d);
            end
            if ($urandom_range(0, 99) < 85) begin
                dat = ~{1'($urandom_range(0, 1)), ($urandom_range(0, 16) == 16) ? 7'd0 : GL[$urandom_range(0, 15)]};
            end else begin
                dat = 8'($urandom);
            end
            reps = $urandom_range(1, 3);
            for (int k = 0; k < reps; k++) begin
                if ($urandom_range(0, 99) < 30) idle(1);
                drive(0, 1, s, dat);
            end
        end
        idle(4);
        check("frames_pending", 32'(q_dig.size()), 32'd0);
        check("errors_pending", 32'(q_err.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
